// File: rtl/alu_seq_pkg.sv
// Opcodes, FSM states and flag helpers shared by the alu_seq datapath.
// FnMUL is decoded only when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

  typedef enum logic [4:0] {
    FnA    = 5'd0,
    FnB    = 5'd1,
    FnADD  = 5'd2,
    FnADC  = 5'd3,
    FnSUB  = 5'd4,
    FnSUC  = 5'd5,
    FnNEG  = 5'd6,
    FnINC  = 5'd7,
    FnDEC  = 5'd8,
    FnAND  = 5'd9,
    FnOR   = 5'd10,
    FnXOR  = 5'd11,
    FnNOT  = 5'd12,
    FnNAND = 5'd13,
    FnNOR  = 5'd14,
    FnLSL  = 5'd15,
    FnLSR  = 5'd16,
    FnASR  = 5'd17,
    FnLUI  = 5'd18,
    FnLLI  = 5'd19,
    FnMUL  = 5'd20
  } alu_functions_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2
  } alu_state_t;

  localparam int unsigned FlagZ = 0;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 2;
  localparam int unsigned FlagN = 3;

  function automatic logic [3:0] packFlags(input logic z, input logic c,
                                           input logic v, input logic n);
    logic [3:0] f;
    f = 4'b0000;
    f[FlagZ] = z;
    f[FlagC] = c;
    f[FlagV] = v;
    f[FlagN] = n;
    return f;
  endfunction

  function automatic logic isShiftOp(input alu_functions_t fn);
    return (fn == FnLSL) || (fn == FnLSR) || (fn == FnASR);
  endfunction

endpackage

// File: rtl/alu_seq_addsub.sv
// Combinational WIDTH-bit adder with optional B inversion and carry-in;
// shared by every add, subtract, negate, increment and decrement op.
module alu_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             invB,
  input  logic             cIn,
  output logic [WIDTH-1:0] sum,
  output logic             cOut,
  output logic             ovf
);

  logic [WIDTH-1:0] bEff_s;
  logic [WIDTH:0]   full_s;

  assign bEff_s = invB ? ~b : b;
  assign full_s = {1'b0, a} + {1'b0, bEff_s} + {{WIDTH{1'b0}}, cIn};
  assign sum    = full_s[WIDTH-1:0];
  assign cOut   = full_s[WIDTH];
  // Overflow: both addends share a sign that the sum does not.
  assign ovf    = (a[WIDTH-1] == bEff_s[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with Start/Busy/Done handshake and iterative shifts.
// Define ALU_SEQ_MUL_EN to add the FnMUL shift-add multiplier.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  alu_functions_t   Func,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Flags
);

  localparam int HALF = WIDTH / 2;
  localparam int CNT_W = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  alu_state_t       state_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] shiftVal_r;
  alu_functions_t   op_r;

  logic [WIDTH-1:0] asA_s, asB_s, asSum_s;
  logic             asInv_s, asCin_s, asCout_s, asOvf_s;
  logic [WIDTH-1:0] opRes_s, shiftNext_s;
  logic             opC_s, opV_s, opKeep_s, shiftOut_s;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [CNT_W-1:0] MUL_ITER = CNT_W'(WIDTH);
  logic [WIDTH-1:0] mulHi_r, mulLo_r, mulMcand_r;
  logic [WIDTH:0]   mulSum_s;
  logic [WIDTH-1:0] mulHiNext_s, mulLoNext_s;

  // One shift-add iteration: conditionally add multiplicand, shift product right.
  assign mulSum_s    = {1'b0, mulHi_r} + (mulLo_r[0] ? {1'b0, mulMcand_r} : {(WIDTH+1){1'b0}});
  assign mulHiNext_s = mulSum_s[WIDTH:1];
  assign mulLoNext_s = {mulSum_s[0], mulLo_r[WIDTH-1:1]};
`endif

  alu_addsub #(.WIDTH(WIDTH)) uAddSub (
    .a    (asA_s),
    .b    (asB_s),
    .invB (asInv_s),
    .cIn  (asCin_s),
    .sum  (asSum_s),
    .cOut (asCout_s),
    .ovf  (asOvf_s)
  );

  // Adder operand steering for the arithmetic ops.
  always_comb begin
    asA_s   = A;
    asB_s   = B;
    asInv_s = 1'b0;
    asCin_s = 1'b0;
    case (Func)
      FnADC: asCin_s = CIn;
      FnSUB: begin asInv_s = 1'b1; asCin_s = 1'b1; end
      FnSUC: begin asInv_s = 1'b1; asCin_s = CIn; end
      FnNEG: begin asA_s = {WIDTH{1'b0}}; asB_s = A; asInv_s = 1'b1; asCin_s = 1'b1; end
      FnINC: begin asB_s = {WIDTH{1'b0}}; asCin_s = 1'b1; end
      FnDEC: begin asB_s = {{(WIDTH-1){1'b0}}, 1'b1}; asInv_s = 1'b1; asCin_s = 1'b1; end
      default: asCin_s = 1'b0;
    endcase
  end

  // Single-cycle result; zero-length shifts pass A through, unknown codes keep flags.
  always_comb begin
    opRes_s  = A;
    opC_s    = 1'b0;
    opV_s    = 1'b0;
    opKeep_s = 1'b0;
    case (Func)
      FnA:    opRes_s = A;
      FnB:    opRes_s = B;
      FnADD, FnADC, FnSUB, FnSUC, FnNEG, FnINC, FnDEC: begin
        opRes_s = asSum_s;
        opC_s   = asCout_s;
        opV_s   = asOvf_s;
      end
      FnAND:  opRes_s = A & B;
      FnOR:   opRes_s = A | B;
      FnXOR:  opRes_s = A ^ B;
      FnNOT:  opRes_s = ~A;
      FnNAND: opRes_s = ~(A & B);
      FnNOR:  opRes_s = ~(A | B);
      FnLUI:  opRes_s = {B[HALF-1:0], A[HALF-1:0]};
      FnLLI:  opRes_s = {A[WIDTH-1:HALF], B[HALF-1:0]};
      FnLSL, FnLSR, FnASR: opRes_s = A;
      default: begin
        opRes_s  = A;
        opKeep_s = 1'b1;
      end
    endcase
  end

  // One-bit shift step and the bit it pushes out.
  always_comb begin
    shiftNext_s = shiftVal_r;
    shiftOut_s  = 1'b0;
    case (op_r)
      FnLSL: begin shiftNext_s = {shiftVal_r[WIDTH-2:0], 1'b0}; shiftOut_s = shiftVal_r[WIDTH-1]; end
      FnLSR: begin shiftNext_s = {1'b0, shiftVal_r[WIDTH-1:1]}; shiftOut_s = shiftVal_r[0]; end
      FnASR: begin shiftNext_s = {shiftVal_r[WIDTH-1], shiftVal_r[WIDTH-1:1]}; shiftOut_s = shiftVal_r[0]; end
      default: shiftOut_s = 1'b0;
    endcase
  end

  // Control FSM and output registers; Result/Flags move only with Done.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r    <= IDLE;
      count_r    <= {CNT_W{1'b0}};
      shiftVal_r <= {WIDTH{1'b0}};
      op_r       <= FnA;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Result     <= {WIDTH{1'b0}};
      Flags      <= 4'b0000;
`ifdef ALU_SEQ_MUL_EN
      mulHi_r    <= {WIDTH{1'b0}};
      mulLo_r    <= {WIDTH{1'b0}};
      mulMcand_r <= {WIDTH{1'b0}};
`endif
    end else begin
      Done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (Start) begin
            if (isShiftOp(Func) && (B[SHAMT_W-1:0] != {SHAMT_W{1'b0}})) begin
              state_r    <= SHIFT;
              Busy       <= 1'b1;
              count_r    <= {1'b0, B[SHAMT_W-1:0]};
              shiftVal_r <= A;
              op_r       <= Func;
`ifdef ALU_SEQ_MUL_EN
            end else if (Func == FnMUL) begin
              state_r    <= MUL;
              Busy       <= 1'b1;
              count_r    <= MUL_ITER;
              mulHi_r    <= {WIDTH{1'b0}};
              mulLo_r    <= B;
              mulMcand_r <= A;
`endif
            end else begin
              Result <= opRes_s;
              Done   <= 1'b1;
              if (!opKeep_s) begin
                Flags <= packFlags(opRes_s == {WIDTH{1'b0}}, opC_s, opV_s, opRes_s[WIDTH-1]);
              end
            end
          end
        end
        SHIFT: begin
          shiftVal_r <= shiftNext_s;
          count_r    <= count_r - CNT_ONE;
          if (count_r == CNT_ONE) begin
            state_r <= IDLE;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            Result  <= shiftNext_s;
            Flags   <= packFlags(shiftNext_s == {WIDTH{1'b0}}, shiftOut_s, 1'b0, shiftNext_s[WIDTH-1]);
          end
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          mulHi_r <= mulHiNext_s;
          mulLo_r <= mulLoNext_s;
          count_r <= count_r - CNT_ONE;
          if (count_r == CNT_ONE) begin
            state_r <= IDLE;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            Result  <= mulLoNext_s;
            Flags   <= packFlags(mulLoNext_s == {WIDTH{1'b0}}, mulHiNext_s != {WIDTH{1'b0}},
                                 1'b0, mulLoNext_s[WIDTH-1]);
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered, multi-cycle ALU for the next-generation datapath. Generalises the 16-bit single-cycle ALU function set to WIDTH bits.
- Adds multi-bit shifts, executed iteratively at one bit per cycle.
- Uses a Start/Busy/Done handshake so the control FSM can stall on long operations.
- Sits between the operand muxes (Op1/Op2 select) and the writeback mux; holds result and Z/C/V/N flags in output registers.

Parameters:
- WIDTH, 16, datapath width; even, ≥ 8.
- SHAMT_W, $clog2(WIDTH), width of the shift-amount field taken from B.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only when Busy=0.
- Func  in  5  operation code, type alu_functions_t.
- A  in  WIDTH  operand 1.
- B  in  WIDTH  operand 2; B[SHAMT_W-1:0] is the shift amount.
- CIn  in  1  carry-in for FnADC and FnSUC.
- Busy  out  1  high while a multi-cycle operation is in progress.
- Done  out  1  one-cycle pulse: Result and Flags are updated this cycle.
- Result  out  WIDTH  registered result; held between completions.
- Flags  out  4  registered flags: [0]=Z, [1]=C, [2]=V, [3]=N.

Behaviour:
- Reset: Result=0, Flags=0, Busy=0, Done=0, state=IDLE. Reset takes priority over everything, including mid-operation; any partial shift or multiply is discarded.
- States: IDLE, SHIFT, MUL. Done is asserted in the cycle after the final state update.
- Start accepted at edge t when Busy=0. Back-to-back issue in the Done cycle is allowed. Start while Busy=1 is ignored.
- Single-cycle ops: FnA, FnB, FnADD, FnADC, FnSUB, FnSUC, FnNEG, FnAND, FnOR, FnXOR, FnNOT, FnNAND, FnNOR, FnLUI, FnLLI, FnINC, FnDEC.
  - Result, Flags and Done are valid at t+1. Busy is never asserted.
- Arithmetic:
  - ADD = A+B; ADC = A+B+CIn; SUB = A+~B+1; SUC = A+~B+CIn.
  - NEG = 0−A; INC = A+1; DEC = A+~1+1.
  - C = carry-out of the WIDTH-bit sum, so for subtract C=1 means no borrow.
  - V = signed overflow.
- Logic ops, FnA, FnB, LUI, LLI: C=0, V=0.
- LUI: Result = {B[WIDTH/2-1:0], A[WIDTH/2-1:0]}. LLI: Result = {A[WIDTH-1:WIDTH/2], B[WIDTH/2-1:0]}.
- Z = (Result==0) and N = Result[WIDTH-1] for every op.
- Shifts (FnLSL, FnLSR, FnASR), amount k = B[SHAMT_W-1:0]:
  - k=0: completes like a single-cycle op; Result=A, C=0.
  - k>0: enter SHIFT with a down-counter of k. Shift one bit per cycle; C = last bit shifted out. ASR replicates the MSB. V=0.
  - Busy high for cycles t+1..t+k; Done at t+k+1.
- Undefined Func code: Result=A, Flags unchanged, Done at t+1.
- Done is never asserted without a preceding accepted Start. Result and Flags change only on Done cycles or on Reset.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: adds FnMUL, an unsigned shift-add multiply over WIDTH iterations in state MUL.
  - Busy high for t+1..t+WIDTH; Done at t+WIDTH+1.
  - Result = low WIDTH bits of A*B; C = (high half ≠ 0); V=0.
- Undefined: FnMUL is treated as an undefined code (Result=A, Flags unchanged). No MUL state or multiplier registers are synthesised.

Decomposition:
- Package opcodes:
  - extend alu_functions_t with FnMUL = 5'd20, appended after FnLLI so existing encodings are unchanged;
  - add alu_state_t {IDLE, SHIFT, MUL};
  - keep the flag-index defines (Z=0, C=1, V=2, N=3) shared.
- One sub-module, alu_addsub: combinational WIDTH-bit adder with invert-B and carry-in, producing sum, carry-out and overflow. Shared by all add, subtract, negate, INC and DEC ops.

Test Plan:
1. Signed overflow: FnADD A=16'h7FFF, B=16'h0001 → Done at t+1; Result=16'h8000; N=1, V=1, C=0, Z=0.
2. Equal subtract: FnSUB A=16'h0005, B=16'h0005 → Result=0; Z=1, C=1, V=0, N=0.
3. Arithmetic shift: FnASR A=16'h8000, B=4 → Busy high 4 cycles; Done at t+5; Result=16'hF800; C=0, N=1. Then FnLSL A=16'h8001, B=1 → Result=16'h0002, C=1.
4. Handshake: Start FnLSR B=3; pulse Start with FnADD during Busy → ignored. Start FnAND in the Done cycle → accepted, Done again one cycle later.
5. Reset mid-operation: assert Reset at t+2 of an LSL B=7 → next cycle Result=0, Flags=0, Busy=0, Done=0, and no stale Done afterwards.
6. Multiply (ALU_SEQ_MUL_EN): FnMUL A=16'h0100, B=16'h0100 → Done at t+17; Result=0; Z=1, C=1. Without the macro, the same stimulus gives Result=16'h0100 at t+1 with Flags unchanged.
